// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared types, widths and load-use helper for the hazard controller
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2,
        ERR   = 2'd3
    } hazState_e;

    localparam int REG_IDX_W       = 5;
    localparam int DEF_MEM_TIMEOUT = 16;

    // Register 0 is hard-wired zero, so a load targeting it never creates a dependency.
    function automatic logic isLoadUse(
        input logic                 memRead,
        input logic [REG_IDX_W-1:0] exRt,
        input logic [REG_IDX_W-1:0] idRs,
        input logic [REG_IDX_W-1:0] idRt
    );
        return memRead && (exRt != '0) && ((exRt == idRs) || (exRt == idRt));
    endfunction

endpackage

// File: rtl/hazard_stats.sv
// rtl/hazard_stats.sv - saturating event counters for bubbles, flushes and hold cycles
module hazard_stats (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stallEv,
    input  logic        flushEv,
    input  logic        holdEv,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
    output logic [15:0] hold_cnt
);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            hold_cnt  <= '0;
        end else begin
            if (stallEv && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
            if (flushEv && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
            if (holdEv  && hold_cnt  != 16'hFFFF) hold_cnt  <= hold_cnt  + 16'd1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/bubble/flush/freeze sequencer; HAZARD_STATS_EN adds event counters
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [REG_IDX_W-1:0] if_id_RegRs,
    input  logic [REG_IDX_W-1:0] if_id_RegRt,
    input  logic                 id_ex_MemRead,
    input  logic [REG_IDX_W-1:0] id_ex_RegRt,
    input  logic                 branch_taken,
    input  logic                 dmem_req,
    input  logic                 dmem_ready,
    output logic                 pc_write,
    output logic                 if_id_write,
    output logic                 id_ex_bubble,
    output logic                 flush,
    output logic                 pipe_hold,
    output logic                 mem_err
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]          stall_cnt,
    output logic [15:0]          flush_cnt,
    output logic [15:0]          hold_cnt
`endif
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    hazState_e        state, nextState;
    logic             pend, pendNext;
    logic [CNT_W-1:0] holdCnt, cntNext;
    logic             loadUse, memStall;

    assign loadUse  = isLoadUse(id_ex_MemRead, id_ex_RegRt, if_id_RegRs, if_id_RegRt);
    assign memStall = dmem_req && !dmem_ready;
    assign mem_err  = (state == ERR);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state   <= RUN;
            pend    <= 1'b0;
            holdCnt <= '0;
        end else begin
            state   <= nextState;
            pend    <= pendNext;
            holdCnt <= cntNext;
        end
    end

    always_comb begin
        nextState    = state;
        pendNext     = pend;
        cntNext      = holdCnt;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        flush        = 1'b0;
        pipe_hold    = 1'b0;

        case (state)
            RUN: begin
                if (memStall) begin
                    // A branch resolving in the entry cycle is remembered and flushed after the hold.
                    pipe_hold   = 1'b1;
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    pendNext    = branch_taken;
                    cntNext     = CNT_W'(1);
                    nextState   = HOLD;
                end else if (branch_taken) begin
                    flush = 1'b1;
                end else if (loadUse) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                end
            end

            HOLD: begin
                pipe_hold   = 1'b1;
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                if (dmem_ready) begin
                    nextState = (pend || branch_taken) ? FLUSH : RUN;
                    pendNext  = 1'b0;
                    cntNext   = '0;
                end else if (holdCnt == CNT_W'(MEM_TIMEOUT)) begin
                    nextState = ERR;
                    pendNext  = pend || branch_taken;
                end else begin
                    cntNext  = holdCnt + CNT_W'(1);
                    pendNext = pend || branch_taken;
                end
            end

            FLUSH: begin
                flush     = 1'b1;
                nextState = RUN;
                if (memStall) begin
                    // The deferred flush still goes out; a new access can freeze the pipe again.
                    pipe_hold   = 1'b1;
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    pendNext    = 1'b0;
                    cntNext     = CNT_W'(1);
                    nextState   = HOLD;
                end
            end

            ERR: begin
                pipe_hold   = 1'b1;
                pc_write    = 1'b0;
                if_id_write = 1'b0;
            end

            default: nextState = RUN;
        endcase
    end

`ifdef HAZARD_STATS_EN
    hazard_stats u_stats (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .stallEv   (id_ex_bubble),
        .flushEv   (flush),
        .holdEv    (pipe_hold),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
        .hold_cnt  (hold_cnt)
    );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl (MEM_TIMEOUT=4), optional HAZARD_STATS_EN checks
module tb_hazard_ctrl;

    // Expected output vector bit order: {pc_write, if_id_write, id_ex_bubble, flush, pipe_hold, mem_err}
    localparam logic [5:0] NORM  = 6'b110000;
    localparam logic [5:0] STALL = 6'b001000;
    localparam logic [5:0] FL    = 6'b110100;
    localparam logic [5:0] HOLDV = 6'b000010;
    localparam logic [5:0] FLHLD = 6'b000110;
    localparam logic [5:0] ERRV  = 6'b000011;

    typedef struct {
        string      name;
        logic [5:0] exp;
    } sbEntry_t;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [4:0] if_id_RegRs = '0;
    logic [4:0] if_id_RegRt = '0;
    logic       id_ex_MemRead = 1'b0;
    logic [4:0] id_ex_RegRt = '0;
    logic       branch_taken = 1'b0;
    logic       dmem_req = 1'b0;
    logic       dmem_ready = 1'b0;
    logic       pc_write, if_id_write, id_ex_bubble, flush, pipe_hold, mem_err;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt, flush_cnt, hold_cnt;
`endif

    sbEntry_t sb[$];
    int checks = 0;
    int errors = 0;
    bit done   = 1'b0;

    always #5 clk_i = ~clk_i;

    hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .if_id_RegRs   (if_id_RegRs),
        .if_id_RegRt   (if_id_RegRt),
        .id_ex_MemRead (id_ex_MemRead),
        .id_ex_RegRt   (id_ex_RegRt),
        .branch_taken  (branch_taken),
        .dmem_req      (dmem_req),
        .dmem_ready    (dmem_ready),
        .pc_write      (pc_write),
        .if_id_write   (if_id_write),
        .id_ex_bubble  (id_ex_bubble),
        .flush         (flush),
        .pipe_hold     (pipe_hold),
        .mem_err       (mem_err)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt),
        .hold_cnt      (hold_cnt)
`endif
    );

    // Drive one cycle of inputs just after the rising edge and queue what the outputs must be.
    task automatic step(input string nm, input logic rst, input logic mr, input logic [4:0] exRt,
                        input logic [4:0] rs, input logic [4:0] rt, input logic bt,
                        input logic req, input logic rdy, input logic [5:0] exp);
        sbEntry_t e;
        rst_i         = rst;
        id_ex_MemRead = mr;
        id_ex_RegRt   = exRt;
        if_id_RegRs   = rs;
        if_id_RegRt   = rt;
        branch_taken  = bt;
        dmem_req      = req;
        dmem_ready    = rdy;
        e.name = nm;
        e.exp  = exp;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input string nm, input logic [5:0] exp);
        step(nm, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, exp);
    endtask

    task automatic checkVal(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: outputs are combinational, so every queued cycle is sampled mid-cycle on the falling edge.
    initial begin
        sbEntry_t e;
        logic [5:0] act;
        forever begin
            @(negedge clk_i);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {pc_write, if_id_write, id_ex_bubble, flush, pipe_hold, mem_err};
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %b expected %b (pc,ifid,bub,flush,hold,err)", e.name, act, e.exp);
                end
            end
        end
    end

    initial begin
        #100000;
        if (!done) begin
            $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
            $fatal(1, "watchdog");
        end
    end

    initial begin
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        step("reset", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NORM);
        idle("idle", NORM);

        step("lu_rs",      1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, STALL);
        idle("lu_after", NORM);
        step("lu_rt",      1'b1, 1'b1, 5'd8, 5'd3, 5'd8, 1'b0, 1'b0, 1'b0, STALL);
        step("lu_r0",      1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NORM);
        step("lu_nomatch", 1'b1, 1'b1, 5'd5, 5'd6, 5'd7, 1'b0, 1'b0, 1'b0, NORM);
        step("noload",     1'b1, 1'b0, 5'd8, 5'd8, 5'd8, 1'b0, 1'b0, 1'b0, NORM);
        step("br_vs_lu",   1'b1, 1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, FL);

        step("mw_entry", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, HOLDV);
        step("mw_h1",    1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, HOLDV);
        step("mw_h2",    1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, HOLDV);
        step("mw_done",  1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, HOLDV);
        idle("mw_after", NORM);

        step("rdy_entry", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, NORM);
        idle("rdy_after", NORM);

        step("df_entry", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, HOLDV);
        step("df_h1",    1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, HOLDV);
        step("df_h2_br", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, HOLDV);
        step("df_done",  1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, HOLDV);
        idle("df_flush", FL);
        idle("df_once", NORM);

        step("de_entry_br", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, HOLDV);
        step("de_done",     1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, HOLDV);
        step("de_flush_lu", 1'b1, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, FL);
        idle("de_after", NORM);

        step("fh_entry_br", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, HOLDV);
        step("fh_done",     1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, HOLDV);
        step("fh_flush_req",1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, FLHLD);
        step("fh_h_done",   1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, HOLDV);
        idle("fh_noflush", NORM);

        step("tb_entry", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, HOLDV);
        step("tb_h1",    1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, HOLDV);
        step("tb_h2",    1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, HOLDV);
        step("tb_h3",    1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, HOLDV);
        step("tb_h4_rdy",1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, HOLDV);
        idle("tb_after", NORM);

        step("rh_entry", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, HOLDV);
        step("rh_h1_br", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, HOLDV);
        step("rh_reset", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, HOLDV);
        idle("rh_noflush", NORM);

        step("to_entry", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, HOLDV);
        step("to_h1",    1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, HOLDV);
        step("to_h2",    1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, HOLDV);
        step("to_h3",    1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, HOLDV);
        step("to_h4",    1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, HOLDV);
        step("err_1",    1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, ERRV);
        step("err_rdy",  1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, ERRV);
        step("err_lu",   1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, ERRV);
        step("err_rst",  1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, ERRV);
        idle("err_clear", NORM);

        // Stats segment: 3 bubbles, 2 flushes, 5 hold cycles after a fresh reset.
        step("st_reset", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NORM);
        for (int i = 0; i < 3; i++) begin
            step("st_lu", 1'b1, 1'b1, 5'd12, 5'd0, 5'd12, 1'b0, 1'b0, 1'b0, STALL);
            idle("st_lu_gap", NORM);
        end
        step("st_br1", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, FL);
        step("st_br2", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, FL);
        for (int i = 0; i < 4; i++)
            step("st_hold", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, HOLDV);
        step("st_hold_done", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, HOLDV);
        idle("st_end", NORM);

        @(negedge clk_i);
        @(negedge clk_i);
        checkVal("sb_drained", sb.size(), 0);
`ifdef HAZARD_STATS_EN
        checkVal("stall_cnt", int'(stall_cnt), 3);
        checkVal("flush_cnt", int'(flush_cnt), 2);
        checkVal("hold_cnt",  int'(hold_cnt), 5);
`endif
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
